// File: rtl/nonce_dispatch_scheduler.sv
// rtl/nonce_dispatch_scheduler.sv - nonce sweep dispatcher and result collector for parallel hash cores; NONCE_SCHED_PERF_EN adds perf_cycles
module nonce_dispatch_scheduler #(
    parameter int NUM_CORES  = 4,
    parameter int NUM_NONCES = 16,
    parameter int ADDR_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       output_addr,
    output logic                    done,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [31:0]             core_nonce,
    input  logic [NUM_CORES-1:0]    res_valid,
    input  logic [32*NUM_CORES-1:0] res_nonce,
    input  logic [32*NUM_CORES-1:0] res_data,
    output logic [NUM_CORES-1:0]    res_ready,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [31:0]             mem_write_data
`ifdef NONCE_SCHED_PERF_EN
    ,
    output logic [31:0]             perf_cycles
`endif
);
    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = 17;
    localparam logic [CNT_W-1:0] TOTAL = CNT_W'(NUM_NONCES);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
    state_t state_q, state_d;

    logic [NUM_CORES-1:0] assigned_q;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [CNT_W-1:0]     issued_q;
    logic [CNT_W-1:0]     written_q;
    logic [ADDR_W-1:0]    base_q;

    logic                 start_acc;
    logic                 collect_en;
    logic                 disp_en;
    logic                 disp_any;
    logic                 xfer;
    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] disp_onehot;
    logic [NUM_CORES-1:0] grant;
    logic [PTR_W-1:0]     disp_idx;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     cand;
    logic [PTR_W-1:0]     rr_next;
    logic [ADDR_W-1:0]    sel_nonce;
    logic [31:0]          sel_data;
    int                   idx;

    assign start_acc  = (state_q == IDLE) && start;
    assign collect_en = (state_q == RUN) || (state_q == DRAIN);
    assign eligible   = collect_en ? (res_valid & assigned_q) : '0;
    assign res_ready  = grant;

    // Sweep sequencing: IDLE -> RUN (dispatch+collect) -> DRAIN (collect) -> FIN (done pulse)
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (issued_q == TOTAL) state_d = DRAIN;
            DRAIN:   if (written_q == TOTAL) state_d = FIN;
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pick the lowest idle core; uses pre-transfer assigned so a core freed this cycle waits one cycle
    always_comb begin
        disp_any = 1'b0;
        disp_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (!assigned_q[i]) begin
                disp_any = 1'b1;
                disp_idx = PTR_W'(i);
            end
        end
        disp_en     = (state_q == RUN) && (issued_q < TOTAL) && disp_any;
        disp_onehot = NUM_CORES'(disp_en) << disp_idx;
    end

    // Round-robin grant starting at rr_ptr; scanning downward leaves the nearest eligible core
    always_comb begin
        grant_idx = '0;
        xfer      = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            cand = PTR_W'(idx);
            if (eligible[cand]) begin
                grant_idx = cand;
                xfer      = 1'b1;
            end
        end
        grant   = NUM_CORES'(xfer) << grant_idx;
        rr_next = (grant_idx == PTR_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Mux the granted core's nonce tag and H0 word onto the write path
    always_comb begin
        sel_nonce = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) begin
                sel_nonce = res_nonce[32*i +: ADDR_W];
                sel_data  = res_data[32*i +: 32];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Dispatch/collect datapath: registered pulses, core bookkeeping, memory write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_start     <= '0;
            core_nonce     <= '0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            assigned_q     <= '0;
            rr_ptr_q       <= '0;
            issued_q       <= '0;
            written_q      <= '0;
            base_q         <= '0;
        end else begin
            core_start <= disp_onehot;
            mem_we     <= xfer;
            assigned_q <= (assigned_q & ~grant) | disp_onehot;
            if (start_acc) begin
                base_q    <= output_addr;
                issued_q  <= '0;
                written_q <= '0;
            end
            if (disp_en) begin
                core_nonce <= 32'(issued_q);
                issued_q   <= issued_q + 1'b1;
            end
            if (xfer) begin
                mem_addr       <= base_q + sel_nonce;
                mem_write_data <= sel_data;
                written_q      <= written_q + 1'b1;
                rr_ptr_q       <= rr_next;
            end
        end
    end

`ifdef NONCE_SCHED_PERF_EN
    // Busy-cycle counter: cleared on start accept, counts RUN/DRAIN, holds otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           perf_cycles <= '0;
        else if (start_acc)  perf_cycles <= '0;
        else if (collect_en) perf_cycles <= perf_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_nonce_dispatch_scheduler.sv
// tb/tb_nonce_dispatch_scheduler.sv - scoreboard bench for nonce_dispatch_scheduler
module tb_nonce_dispatch_scheduler;
    localparam int NC    = 4;
    localparam int LAT_A = 10;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A: 4 cores, 16 nonces ----------------
    logic               a_start = 1'b0;
    logic [15:0]        a_out_addr = '0;
    logic               a_done;
    logic [NC-1:0]      a_core_start;
    logic [31:0]        a_core_nonce;
    logic [NC-1:0]      a_valid;
    logic [32*NC-1:0]   a_rnonce;
    logic [32*NC-1:0]   a_rdata;
    logic [NC-1:0]      a_ready;
    logic               a_we;
    logic [15:0]        a_addr;
    logic [31:0]        a_wdata;
`ifdef NONCE_SCHED_PERF_EN
    logic [31:0]        a_perf;
`endif

    nonce_dispatch_scheduler #(.NUM_CORES(NC), .NUM_NONCES(16), .ADDR_W(16)) u_dut (
        .clk(clk), .reset(reset), .start(a_start), .output_addr(a_out_addr), .done(a_done),
        .core_start(a_core_start), .core_nonce(a_core_nonce), .res_valid(a_valid),
        .res_nonce(a_rnonce), .res_data(a_rdata), .res_ready(a_ready), .mem_we(a_we),
        .mem_addr(a_addr), .mem_write_data(a_wdata)
`ifdef NONCE_SCHED_PERF_EN
        , .perf_cycles(a_perf)
`endif
    );

    int          a_cnt [NC];
    logic [NC-1:0] a_busy;
    logic [NC-1:0] hold_mask = '0;
    logic [15:0] a_base = '0;
    logic [47:0] a_q[$];
    int          grant_log[$];
    int          grant_cyc[$];
    int          a_exp_nonce = 0;
    int          a_writes = 0;
    int          a_dones = 0;

    // Hash core models for A: reply after LAT_A cycles unless held, drop valid on accept
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            a_valid <= '0;
            a_busy  <= '0;
            for (int i = 0; i < NC; i++) a_cnt[i] <= 0;
            a_q.delete();
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (a_valid[i] && a_ready[i]) begin
                    a_valid[i] <= 1'b0;
                    a_busy[i]  <= 1'b0;
                    a_q.push_back({16'(a_base + a_rnonce[32*i +: 16]), a_rdata[32*i +: 32]});
                    grant_log.push_back(i);
                    grant_cyc.push_back(cyc);
                end else if (a_busy[i] && !a_valid[i]) begin
                    if (a_cnt[i] > 0) a_cnt[i] <= a_cnt[i] - 1;
                    else if (!hold_mask[i]) a_valid[i] <= 1'b1;
                end
                if (a_core_start[i]) begin
                    a_busy[i]             <= 1'b1;
                    a_cnt[i]              <= LAT_A;
                    a_rnonce[32*i +: 32]  <= a_core_nonce;
                    a_rdata[32*i +: 32]   <= 32'hA000_0000 + a_core_nonce;
                end
            end
        end
    end

    // Monitor A away from the active edge
    always @(negedge clk) begin
        logic [47:0] w;
        if (!reset) begin
            if (a_core_start != '0) begin
                chk("a_start_onehot", 64'($onehot(a_core_start)), 64'd1);
                chk("a_start_to_free_core", 64'(|(a_core_start & a_busy)), 64'd0);
                chk("a_core_nonce", 64'(a_core_nonce), 64'(a_exp_nonce));
                a_exp_nonce++;
            end
            if (a_we) begin
                if (a_q.size() == 0) begin
                    chk("a_unexpected_write", 64'd1, 64'd0);
                end else begin
                    w = a_q.pop_front();
                    chk("a_mem_addr", 64'(a_addr), 64'(w[47:32]));
                    chk("a_mem_data", 64'(a_wdata), 64'(w[31:0]));
                end
                a_writes++;
            end
            if (a_done) a_dones++;
        end
    end

    // ---------------- instance B: 4 cores, 2 nonces ----------------
    logic               b_start = 1'b0;
    logic [15:0]        b_out_addr = '0;
    logic               b_done;
    logic [NC-1:0]      b_core_start;
    logic [31:0]        b_core_nonce;
    logic [NC-1:0]      b_valid;
    logic [32*NC-1:0]   b_rnonce;
    logic [32*NC-1:0]   b_rdata;
    logic [NC-1:0]      b_ready;
    logic               b_we;
    logic [15:0]        b_addr;
    logic [31:0]        b_wdata;
`ifdef NONCE_SCHED_PERF_EN
    logic [31:0]        b_perf;
`endif

    nonce_dispatch_scheduler #(.NUM_CORES(NC), .NUM_NONCES(2), .ADDR_W(16)) u_small (
        .clk(clk), .reset(reset), .start(b_start), .output_addr(b_out_addr), .done(b_done),
        .core_start(b_core_start), .core_nonce(b_core_nonce), .res_valid(b_valid),
        .res_nonce(b_rnonce), .res_data(b_rdata), .res_ready(b_ready), .mem_we(b_we),
        .mem_addr(b_addr), .mem_write_data(b_wdata)
`ifdef NONCE_SCHED_PERF_EN
        , .perf_cycles(b_perf)
`endif
    );

    int            b_cnt [NC];
    logic [NC-1:0] b_busy;
    logic [15:0]   b_base = '0;
    logic [47:0]   b_q[$];
    logic [NC-1:0] b_seen = '0;
    int            b_exp_nonce = 0;
    int            b_writes = 0;
    int            b_dones = 0;

    // Hash core models for B
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            b_valid <= '0;
            b_busy  <= '0;
            for (int i = 0; i < NC; i++) b_cnt[i] <= 0;
            b_q.delete();
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (b_valid[i] && b_ready[i]) begin
                    b_valid[i] <= 1'b0;
                    b_busy[i]  <= 1'b0;
                    b_q.push_back({16'(b_base + b_rnonce[32*i +: 16]), b_rdata[32*i +: 32]});
                end else if (b_busy[i] && !b_valid[i]) begin
                    if (b_cnt[i] > 0) b_cnt[i] <= b_cnt[i] - 1;
                    else b_valid[i] <= 1'b1;
                end
                if (b_core_start[i]) begin
                    b_busy[i]            <= 1'b1;
                    b_cnt[i]             <= LAT_B;
                    b_rnonce[32*i +: 32] <= b_core_nonce;
                    b_rdata[32*i +: 32]  <= 32'hA000_0000 + b_core_nonce;
                end
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        logic [47:0] w;
        if (!reset) begin
            b_seen = b_seen | b_core_start;
            if (b_core_start != '0) begin
                chk("b_core_nonce", 64'(b_core_nonce), 64'(b_exp_nonce));
                b_exp_nonce++;
            end
            if (b_we) begin
                if (b_q.size() == 0) begin
                    chk("b_unexpected_write", 64'd1, 64'd0);
                end else begin
                    w = b_q.pop_front();
                    chk("b_mem_addr", 64'(b_addr), 64'(w[47:32]));
                    chk("b_mem_data", 64'(b_wdata), 64'(w[31:0]));
                end
                b_writes++;
            end
            if (b_done) b_dones++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic a_sweep_start(input logic [15:0] base);
        @(negedge clk);
        a_out_addr  = base;
        a_base      = base;
        a_exp_nonce = 0;
        a_writes    = 0;
        a_dones     = 0;
        a_start     = 1'b1;
        @(negedge clk);
        a_start     = 1'b0;
    endtask

    task automatic a_finish_sweep(input string tag);
        int n;
        n = 0;
        while (a_dones == 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_in_time"}, 64'(n < 1000), 64'd1);
        repeat (3) @(negedge clk);
        chk({tag, "_writes"}, 64'(a_writes), 64'd16);
        chk({tag, "_done_pulses"}, 64'(a_dones), 64'd1);
        chk({tag, "_queue_empty"}, 64'(a_q.size()), 64'd0);
        chk({tag, "_nonces_issued"}, 64'(a_exp_nonce), 64'd16);
    endtask

    task automatic a_check_quiet(input string tag);
        chk({tag, "_done"}, 64'(a_done), 64'd0);
        chk({tag, "_core_start"}, 64'(a_core_start), 64'd0);
        chk({tag, "_core_nonce"}, 64'(a_core_nonce), 64'd0);
        chk({tag, "_res_ready"}, 64'(a_ready), 64'd0);
        chk({tag, "_mem_we"}, 64'(a_we), 64'd0);
        chk({tag, "_mem_addr"}, 64'(a_addr), 64'd0);
        chk({tag, "_mem_data"}, 64'(a_wdata), 64'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        repeat (3) @(negedge clk);
        a_check_quiet("reset");
        reset = 1'b0;

        // Basic sweep, base 0x20, with a start pulse in RUN that must be ignored
        a_sweep_start(16'h0020);
        repeat (5) @(negedge clk);
        a_out_addr = 16'h0100;
        a_start    = 1'b1;
        @(negedge clk);
        a_start    = 1'b0;
        a_finish_sweep("sweep1");

        // Round-robin: simultaneous rounds from rr_ptr 0 and then rr_ptr 1
        pulse_reset();
        grant_log.delete();
        grant_cyc.delete();
        hold_mask = 4'b1111;
        a_sweep_start(16'h0040);
        repeat (20) @(negedge clk);
        hold_mask = 4'b0000;
        @(negedge clk);
        hold_mask = 4'b1110;
        n = 0;
        while (grant_log.size() < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        hold_mask = 4'b1111;
        repeat (20) @(negedge clk);
        hold_mask = 4'b0000;
        repeat (8) @(negedge clk);
        chk("rr_grant_count", 64'(grant_log.size() >= 9), 64'd1);
        if (grant_log.size() >= 9) begin
            for (int k = 0; k < 4; k++) chk("rr_round1_order", 64'(grant_log[k]), 64'(k));
            for (int k = 1; k < 4; k++)
                chk("rr_round1_consecutive", 64'(grant_cyc[k] - grant_cyc[k-1]), 64'd1);
            chk("rr_solo_core0", 64'(grant_log[4]), 64'd0);
            for (int k = 0; k < 4; k++) chk("rr_round2_order", 64'(grant_log[5+k]), 64'((k + 1) % 4));
        end
        a_finish_sweep("sweep_rr");

        // Reset after five writes, then restart from nonce 0
        a_sweep_start(16'h0020);
        n = 0;
        while (a_writes < 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("midsweep_reached_5_writes", 64'(a_writes >= 5), 64'd1);
        #2 reset = 1'b1;
        #1 a_check_quiet("midsweep_reset");
        @(negedge clk);
        reset = 1'b0;
        a_sweep_start(16'h0300);
        a_finish_sweep("restart");

        // Address wrap at the top of the 16-bit space
        a_sweep_start(16'hFFFE);
        a_finish_sweep("wrap");

        // Fewer nonces than cores
        @(negedge clk);
        b_out_addr = 16'h0080;
        b_base     = 16'h0080;
        b_start    = 1'b1;
        @(negedge clk);
        b_start    = 1'b0;
        n = 0;
        while (b_dones == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("small_done_in_time", 64'(n < 200), 64'd1);
        repeat (3) @(negedge clk);
        chk("small_cores_used", 64'(b_seen), 64'h3);
        chk("small_writes", 64'(b_writes), 64'd2);
        chk("small_done_pulses", 64'(b_dones), 64'd1);
        chk("small_queue_empty", 64'(b_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
